// File: rtl/main_mem_ctrl.sv
// Main-memory controller behind the direct-mapped cache: write-back, then fill read, LATENCY cycles each.
// Level requests are accepted only in IDLE; a one-cycle ready pulse ends each access and HOLD waits for the requester to drop.
module main_mem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mm_read,
  input  logic              mm_write,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WR, RD, RESP, HOLD} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] a_rd;
  logic [ADDR_W-1:0] a_wb;
  logic [DATA_W-1:0] d_wb;
  logic              do_rd;
  logic              mem_we;

  // Contents survive reset; only the power-up image is zero.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  assign mem_we = (state == WR) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[a_wb] <= d_wb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      a_rd  <= '0;
      a_wb  <= '0;
      d_wb  <= '0;
      do_rd <= 1'b0;
      rdata <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mm_read || mm_write) begin
            a_rd  <= rd_addr;
            a_wb  <= wb_addr;
            d_wb  <= wdata;
            do_rd <= mm_read;
            cnt   <= LAT_M1;
            state <= mm_write ? WR : RD;
            busy  <= 1'b1;
          end
        end
        WR: begin
          if (cnt == 4'd0) begin
            // The write-back commits first so a same-address fill sees the new data.
            if (do_rd) begin
              state <= RD;
              cnt   <= LAT_M1;
            end else begin
              state <= RESP;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RD: begin
          if (cnt == 4'd0) begin
            rdata <= mem[a_rd];
            state <= RESP;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= HOLD;
        end
        HOLD: begin
          if (!mm_read && !mm_write) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: a LATENCY=4 instance under test plus a LATENCY=1 instance on the same inputs.
module tb_main_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mm_read = 1'b0;
  logic       mm_write = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] wb_addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata, rdata1;
  logic       ready, busy, ready1, busy1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  main_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .mm_read(mm_read), .mm_write(mm_write),
    .rd_addr(rd_addr), .wb_addr(wb_addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy)
  );

  main_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mm_read(mm_read), .mm_write(mm_write),
    .rd_addr(rd_addr), .wb_addr(wb_addr), .wdata(wdata),
    .rdata(rdata1), .ready(ready1), .busy(busy1)
  );

  typedef struct {
    bit         rd;
    bit         wr;
    logic [7:0] ra;
    logic [7:0] wa;
    logic [7:0] wd;
    int         lat;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Drives one request from IDLE, returns edges from E0 to ready for both instances and the
  // rdata seen during the RESP cycle, then drops the request and checks the RESP/HOLD/IDLE tail.
  task automatic do_access(input string tag, input bit rd, input bit wr,
                           input logic [7:0] ra, input logic [7:0] wa, input logic [7:0] wd,
                           output int lat, output int lat1, output logic [7:0] rdv, output logic [7:0] rdv1);
    mm_read  = rd;
    mm_write = wr;
    rd_addr  = ra;
    wb_addr  = wa;
    wdata    = wd;
    tick();
    lat  = -1;
    lat1 = -1;
    rdv  = 8'hxx;
    rdv1 = 8'hxx;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      tick();
      if (ready1 && lat1 < 0) begin
        lat1 = n;
        rdv1 = rdata1;
      end
      if (ready) begin
        lat = n;
        rdv = rdata;
      end
    end
    mm_read  = 1'b0;
    mm_write = 1'b0;
    tick();
    check({tag, "_ready_width"}, {31'd0, ready}, 32'd0);
    check({tag, "_busy_hold"}, {31'd0, busy}, 32'd1);
    tick();
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int         lat, lat1, pulses;
    logic [7:0] rdv, rdv1;

    //             rd    wr    ra     wa     wd     lat rdata
    vecs[0] = '{1'b0, 1'b1, 8'h00, 8'h25, 8'hA7, 4, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h25, 8'h00, 8'h00, 4, 8'hA7};
    vecs[2] = '{1'b1, 1'b1, 8'h40, 8'h40, 8'h5C, 8, 8'h5C};
    vecs[3] = '{1'b1, 1'b0, 8'h40, 8'h00, 8'h00, 4, 8'h5C};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h99, 4, 8'h5C};
    vecs[5] = '{1'b1, 1'b1, 8'h01, 8'h81, 8'h11, 8, 8'h99};
    vecs[6] = '{1'b1, 1'b0, 8'h81, 8'h00, 8'h00, 4, 8'h11};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h10, 8'h33, 4, 8'h11};
    vecs[8] = '{1'b1, 1'b0, 8'h77, 8'h00, 8'h00, 4, 8'h00};

    // Reset held with requests toggling; a write to 0x77 must never land.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mm_read  = i[0];
      mm_write = ~i[0];
      rd_addr  = 8'h77;
      wb_addr  = 8'h77;
      wdata    = 8'hFF;
      tick();
      check($sformatf("rst%0d_rdata", i), {24'd0, rdata}, 32'h00);
      check($sformatf("rst%0d_ready", i), {31'd0, ready}, 32'd0);
      check($sformatf("rst%0d_busy", i), {31'd0, busy}, 32'd0);
    end
    mm_read  = 1'b0;
    mm_write = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      do_access($sformatf("v%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].ra, vecs[i].wa, vecs[i].wd,
                lat, lat1, rdv, rdv1);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_rdata", i), {24'd0, rdv}, {24'd0, vecs[i].exp_rdata});
      check($sformatf("v%0d_lat1", i), lat1, vecs[i].lat / 4);
      check($sformatf("v%0d_rdata1", i), {24'd0, rdv1}, {24'd0, vecs[i].exp_rdata});
    end

    // Held level request: one pulse only, address change after acceptance is ignored.
    mm_read = 1'b1;
    rd_addr = 8'h25;
    pulses  = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      rd_addr = 8'h40;
      if (ready) pulses++;
    end
    check("held_pulses", pulses, 1);
    check("held_busy", {31'd0, busy}, 32'd1);
    check("held_rdata", {24'd0, rdata}, 32'hA7);
    mm_read = 1'b0;
    tick();
    check("held_release_busy", {31'd0, busy}, 32'd0);

    // Reset two edges into a write-only access: commit must not happen.
    mm_write = 1'b1;
    wb_addr  = 8'h10;
    wdata    = 8'hEE;
    tick();
    tick();
    tick();
    rst_n    = 1'b0;
    mm_write = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_rdata", {24'd0, rdata}, 32'h00);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ready) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    rst_n = 1'b1;
    do_access("after_rst", 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, lat, lat1, rdv, rdv1);
    check("after_rst_lat", lat, 4);
    check("after_rst_mem10", {24'd0, rdv}, 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_mem_ctrl.md
# main_mem_ctrl

Clocked main-memory controller that sits directly downstream of the 4-line direct-mapped data cache. It accepts line-fill reads (MMRead) and write-backs (MMWrite), stores 256 bytes, and models a fixed, parameterised access latency. Completion is signalled with a single-cycle `ready` pulse. Read data is presented on `rdata`, which drives the cache's MemtoCache input.

## Interface
- `ADDR_W`, default 8: address width; depth is 2^ADDR_W bytes.
- `DATA_W`, default 8: data width.
- `LATENCY`, default 4: cycles per memory access, legal range 1..15.

Ports:
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mm_read`  in  1  line-fill request; level, driven by the cache's MMRead.
- `mm_write`  in  1  write-back request; level, driven by the cache's MMWrite.
- `rd_addr`  in  ADDR_W  fill address (cache ABUS).
- `wb_addr`  in  ADDR_W  write-back (victim) address.
- `wdata`  in  DATA_W  write-back data (cache CachetoMem).
- `rdata`  out  DATA_W  read data to the cache (MemtoCache); registered.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Storage: `mem[0:2^ADDR_W-1]`, initialised to 0 at time zero. Reset does not clear it.
- States: IDLE, WR, RD, RESP, HOLD. `cnt` is a 4-bit down-counter.
- IDLE, any request high at an edge:
  - All inputs are latched into `a_rd`, `a_wb`, `d_wb`, `do_rd`.
  - `cnt` loads LATENCY-1.
  - Next state is WR if `mm_write` is high, else RD.
- WR: `cnt` decrements each edge. At the edge where `cnt`==0:
  - `mem[a_wb]` is written with `d_wb`.
  - If `do_rd` is set, go to RD and reload `cnt` to LATENCY-1. Otherwise go to RESP.
- RD: `cnt` decrements each edge. At the edge where `cnt`==0, `rdata` is loaded from `mem[a_rd]` and the state goes to RESP.
- RESP: lasts exactly one cycle, then the state goes to HOLD.
- HOLD: stays here until both `mm_read` and `mm_write` are sampled low, then returns to IDLE. This prevents a level request that the requester has not yet dropped from re-triggering.
- Simultaneous read and write: the write-back always completes before the fill read. If `a_wb`==`a_rd`, `rdata` returns the newly written `d_wb`.
- Inputs are ignored outside IDLE. Address or data changes during an access have no effect.
- `rdata` holds its value until the next read completes. A write-only access leaves `rdata` unchanged.

## Timing
- Reset values: state IDLE, `cnt` 0, `rdata` 0, `ready` 0, `busy` 0. Latched registers are cleared to 0.
- `ready` is registered: it is 1 exactly while the state is RESP. `busy` is 1 in WR, RD, RESP and HOLD.
- Let E0 be the accepting edge.
  - Read-only or write-only: `ready` is high in the cycle following edge E0+LATENCY. `rdata` is valid in that same cycle.
  - Read and write together: `ready` is high in the cycle following edge E0+2·LATENCY.
  - LATENCY=1: read-only gives `ready` in the cycle after E0+1.
- Minimum spacing between two accepted requests is LATENCY+3 edges: access, RESP, HOLD, then IDLE, assuming the requester drops its request during RESP.
- Reset asserted mid-access: the block returns to IDLE immediately and abandons the access.
  - A write whose commit edge has not occurred is not performed.
  - `rdata` clears to 0; `ready` is never produced for the abandoned access.
- After `rst_n` deasserts, the first edge that sees a request high accepts it.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with requests toggling, then release. Required: `rdata`=0x00, `ready`=0, `busy`=0 throughout, and no access is accepted during reset.
- Read latency: with LATENCY=4 and mem[0x25] preloaded to 0xA7, pulse `mm_read` with `rd_addr`=0x25. Required: `ready` high for exactly one cycle, following E0+4, with `rdata`=0xA7.
- Write then read-back, same address:
  - Raise `mm_write` and `mm_read` together with `wb_addr`=`rd_addr`=0x40 and `wdata`=0x5C.
  - Required: `ready` after E0+8, `rdata`=0x5C, and mem[0x40]=0x5C.
- Eviction pair: `wb_addr`=0x81, `wdata`=0x11, `rd_addr`=0x01 with mem[0x01]=0x99. Required: mem[0x81]=0x11, `rdata`=0x99, and the write commits before the read.
- Held request: keep `mm_read` high for 20 cycles. Required: exactly one `ready` pulse, `busy` stays 1 in HOLD, and the block returns to IDLE one edge after `mm_read` falls.
- Reset mid-write: start a write-only access to 0x10 with `wdata`=0xEE and assert `rst_n`=0 at E0+2. Required: mem[0x10] is unchanged, no `ready` pulse, and the state is IDLE.
